// File: rtl/game_step_scheduler_if.sv
// Handshake bundle between the frame scheduler, the game FSM, the object-update
// engines and the collision checker.
interface game_step_scheduler_if #(
    parameter int N_OBJ = 4
);
    logic [2:0]       game_state;
    logic [N_OBJ-1:0] obj_ack;
    logic             coll_done;
    logic             coll_hit;
    logic [N_OBJ-1:0] obj_req;
    logic             coll_start;
    logic             dead;
    logic             frame_busy;
    logic [15:0]      frame_cnt;
    logic             overrun;
    logic             timeout_err;

    modport master (
        input  game_state, obj_ack, coll_done, coll_hit,
        output obj_req, coll_start, dead, frame_busy, frame_cnt, overrun, timeout_err
    );

    modport slave (
        output game_state, obj_ack, coll_done, coll_hit,
        input  obj_req, coll_start, dead, frame_busy, frame_cnt, overrun, timeout_err
    );
endinterface

// File: rtl/game_step_scheduler.sv
// Per-tick frame scheduler: grants each object engine in turn, runs one
// collision check and reports the result to the game FSM as a dead pulse.
module game_step_scheduler #(
    parameter int N_OBJ    = 4,
    parameter int TICK_DIV = 833334,
    parameter int CNT_W    = 20,
    parameter int TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    game_step_scheduler_if.master  bus
);
    localparam int IDX_W  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] GS_START = 3'b000;
    localparam logic [2:0] GS_PLAY  = 3'b001;
    localparam logic [2:0] GS_RESET = 3'b011;
    localparam logic [2:0] GS_OVER  = 3'b100;

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_HOLD, S_COLL, S_DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_tick_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [WAIT_W-1:0] r_wait;
    logic [N_OBJ-1:0]  r_obj_req;
    logic              r_coll_start;
    logic              r_dead;
    logic              r_frame_busy;
    logic [15:0]       r_frame_cnt;
    logic              r_overrun;
    logic              r_timeout_err;

    logic              w_playing;
    logic              w_abort;
    logic              w_tick;
    logic              w_ack;
    logic              w_tmo;
    logic              w_last;
    logic              w_adv;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [N_OBJ-1:0]  w_req_nxt;

    assign w_playing = (bus.game_state == GS_PLAY);
    assign w_abort   = (bus.game_state == GS_START) || (bus.game_state == GS_RESET) ||
                       (bus.game_state == GS_OVER);
    assign w_tick    = w_playing && (r_tick_cnt == CNT_W'(TICK_DIV - 1));
    assign w_ack     = |(bus.obj_ack & r_obj_req);
    assign w_tmo     = (r_wait == WAIT_W'(TIMEOUT - 1));
    assign w_last    = (r_idx == IDX_W'(N_OBJ - 1));
    assign w_idx_nxt = r_idx + IDX_W'(1);
    assign w_req_nxt = N_OBJ'(1) << w_idx_nxt;
    // Move to the next engine: a finished grant while playing, or leaving a pause.
    assign w_adv     = w_playing &&
                       (((r_state == S_GRANT) && (w_ack || w_tmo)) || (r_state == S_HOLD));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if ((bus.game_state == GS_RESET) || (bus.game_state == GS_START)) begin
            r_tick_cnt <= '0;
        end else if (w_playing) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_wait        <= '0;
            r_obj_req     <= '0;
            r_coll_start  <= 1'b0;
            r_dead        <= 1'b0;
            r_frame_busy  <= 1'b0;
            r_frame_cnt   <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_coll_start <= 1'b0;
            r_dead       <= 1'b0;
            if (bus.game_state == GS_RESET) begin
                r_frame_cnt   <= '0;
                r_overrun     <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            if (w_abort && (r_state != S_IDLE)) begin
                r_state      <= S_IDLE;
                r_idx        <= '0;
                r_wait       <= '0;
                r_obj_req    <= '0;
                r_frame_busy <= 1'b0;
            end else begin
                if (w_tick && (r_state != S_IDLE)) begin
                    r_overrun <= 1'b1;
                end
                case (r_state)
                    S_IDLE: begin
                        if (w_tick) begin
                            r_state      <= S_GRANT;
                            r_idx        <= '0;
                            r_wait       <= '0;
                            r_obj_req    <= N_OBJ'(1);
                            r_frame_busy <= 1'b1;
                        end
                    end
                    S_GRANT: begin
                        if (w_ack || w_tmo) begin
                            if (!w_ack) begin
                                r_timeout_err <= 1'b1;
                            end
                            r_obj_req <= '0;
                            r_state   <= S_HOLD;
                        end else begin
                            r_wait <= r_wait + WAIT_W'(1);
                        end
                    end
                    S_HOLD: ;
                    S_COLL: begin
                        if (bus.coll_done && !r_coll_start) begin
                            r_dead      <= bus.coll_hit;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_state     <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_frame_busy <= 1'b0;
                        r_idx        <= '0;
                        r_state      <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
                // Overrides the HOLD parking chosen above when the frame can proceed.
                if (w_adv) begin
                    if (w_last) begin
                        r_state      <= S_COLL;
                        r_coll_start <= 1'b1;
                        r_obj_req    <= '0;
                    end else begin
                        r_state   <= S_GRANT;
                        r_idx     <= w_idx_nxt;
                        r_obj_req <= w_req_nxt;
                        r_wait    <= '0;
                    end
                end
            end
        end
    end

    assign bus.obj_req     = r_obj_req;
    assign bus.coll_start  = r_coll_start;
    assign bus.dead        = r_dead;
    assign bus.frame_busy  = r_frame_busy;
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.overrun     = r_overrun;
    assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_game_step_scheduler.sv
// Bench for game_step_scheduler: random frames against a timeline model, then
// directed pause, timeout, abort/clear, overrun and async-reset scenarios.
module tb_game_step_scheduler;
    localparam int N_OBJ    = 3;
    localparam int TICK_DIV = 10;
    localparam int CNT_W    = 4;
    localparam int TIMEOUT  = 8;
    localparam int NC       = 400;
    localparam int NF       = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    game_step_scheduler_if #(.N_OBJ(N_OBJ)) bus ();

    game_step_scheduler #(
        .N_OBJ(N_OBJ), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Engine / collision-checker responder state
    int hi [N_OBJ];
    int d_cur [N_OBJ];
    int kc = -1;
    int clat_cur = 1;
    bit hit_cur = 1'b0;
    bit spur_cur = 1'b0;
    int fr = -1;
    bit rand_mode = 1'b0;

    // Per-frame random parameters and expected timeline
    int rd [NF][N_OBJ];
    int rcl [NF];
    bit rhit [NF];
    bit rsp [NF];
    logic [N_OBJ-1:0] e_req [NC];
    bit e_cs [NC], e_dead [NC], e_busy [NC], ev_ovr [NC], ev_to [NC], ev_cnt [NC];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Engines ack d cycles after their req rises (0 = never); the checker answers
    // clat cycles after coll_start, optionally with a junk done in the start cycle.
    task automatic respond();
        logic [N_OBJ-1:0] ack;
        logic dn, hv;
        ack = '0;
        dn  = 1'b0;
        hv  = 1'($urandom);
        for (int i = 0; i < N_OBJ; i++) hi[i] = bus.obj_req[i] ? hi[i] + 1 : 0;
        if (hi[0] == 1) begin
            fr++;
            if (rand_mode && fr < NF) begin
                for (int i = 0; i < N_OBJ; i++) d_cur[i] = rd[fr][i];
                clat_cur = rcl[fr];
                hit_cur  = rhit[fr];
                spur_cur = rsp[fr];
            end
        end
        for (int i = 0; i < N_OBJ; i++) if (d_cur[i] != 0 && hi[i] == d_cur[i]) ack[i] = 1'b1;
        if (rand_mode) ack = ack | (N_OBJ'($urandom) & ~bus.obj_req);
        if (bus.coll_start) kc = 0;
        else if (kc >= 0) kc++;
        if (kc >= 0) begin
            if (kc == clat_cur) begin
                dn = 1'b1;
                hv = hit_cur;
                kc = -1;
            end else if (kc == 0 && spur_cur) begin
                dn = 1'b1;
            end
        end
        bus.obj_ack   = ack;
        bus.coll_done = dn;
        bus.coll_hit  = hv;
    endtask

    // Timeline with state held at PLAYING from cycle 0: ticks every TICK_DIV cycles,
    // each grant lasts min(delay, TIMEOUT), COLL lasts clat+1, then one DONE cycle.
    task automatic build_model();
        int f, dn, s, h;
        for (int c = 0; c < NC; c++) begin
            e_req[c] = '0; e_cs[c] = 0; e_dead[c] = 0; e_busy[c] = 0;
            ev_ovr[c] = 0; ev_to[c] = 0; ev_cnt[c] = 0;
        end
        f  = 0;
        dn = -1;
        for (int t = TICK_DIV - 1; t < NC; t += TICK_DIV) begin
            if (t <= dn) begin
                if (t + 1 < NC) ev_ovr[t + 1] = 1;
            end else if (f < NF) begin
                s = t + 1;
                for (int i = 0; i < N_OBJ; i++) begin
                    h = (rd[f][i] > TIMEOUT) ? TIMEOUT : rd[f][i];
                    for (int k = 0; k < h; k++) if (s + k < NC) e_req[s + k] = N_OBJ'(1 << i);
                    s += h;
                    if (rd[f][i] > TIMEOUT && s < NC) ev_to[s] = 1;
                end
                if (s < NC) e_cs[s] = 1;
                dn = s + rcl[f] + 1;
                if (dn < NC) begin
                    e_dead[dn] = rhit[f];
                    ev_cnt[dn] = 1;
                end
                for (int k = t + 1; k <= dn && k < NC; k++) e_busy[k] = 1;
                f++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"},  32'(bus.obj_req), 32'd0);
        check_val({tag, "_cs"},   32'(bus.coll_start), 32'd0);
        check_val({tag, "_dead"}, 32'(bus.dead), 32'd0);
        check_val({tag, "_busy"}, 32'(bus.frame_busy), 32'd0);
        check_val({tag, "_fcnt"}, 32'(bus.frame_cnt), 32'd0);
        check_val({tag, "_ovr"},  32'(bus.overrun), 32'd0);
        check_val({tag, "_tmo"},  32'(bus.timeout_err), 32'd0);
    endtask

    initial begin
        bit m_ovr, m_to;
        int m_cnt;
        bus.game_state = 3'b000;
        bus.obj_ack    = '0;
        bus.coll_done  = 1'b0;
        bus.coll_hit   = 1'b0;
        for (int i = 0; i < N_OBJ; i++) begin
            hi[i]    = 0;
            d_cur[i] = 2;
        end
        for (int f = 0; f < NF; f++) begin
            for (int i = 0; i < N_OBJ; i++) rd[f][i] = int'($urandom_range(12, 1));
            rcl[f]  = int'($urandom_range(3, 1));
            rhit[f] = 1'($urandom);
            rsp[f]  = 1'($urandom);
        end
        rd[0][0] = TIMEOUT;
        rd[0][2] = TIMEOUT + 4;
        build_model();

        @(posedge clk); #1;
        check_all_zero("rst");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        rand_mode = 1'b1;
        m_ovr = 0; m_to = 0; m_cnt = 0;
        for (int c = 0; c < NC; c++) begin
            @(posedge clk); #1;
            if (c == 0) bus.game_state = 3'b001;
            m_ovr = m_ovr | ev_ovr[c];
            m_to  = m_to | ev_to[c];
            m_cnt = m_cnt + int'(ev_cnt[c]);
            check_val($sformatf("req@%0d", c),  32'(bus.obj_req), 32'(e_req[c]));
            check_val($sformatf("cs@%0d", c),   32'(bus.coll_start), 32'(e_cs[c]));
            check_val($sformatf("dead@%0d", c), 32'(bus.dead), 32'(e_dead[c]));
            check_val($sformatf("busy@%0d", c), 32'(bus.frame_busy), 32'(e_busy[c]));
            check_val($sformatf("fcnt@%0d", c), 32'(bus.frame_cnt), 32'(m_cnt));
            check_val($sformatf("ovr@%0d", c),  32'(bus.overrun), 32'(m_ovr));
            check_val($sformatf("tmo@%0d", c),  32'(bus.timeout_err), 32'(m_to));
            respond();
        end

        rand_mode = 1'b0;
        d_cur     = '{2, 4, 2};
        clat_cur  = 1;
        hit_cur   = 1'b1;
        spur_cur  = 1'b0;
        @(posedge clk); #1;
        bus.game_state = 3'b011;
        respond();
        @(posedge clk); #1;
        check_all_zero("clr");
        respond();

        for (int c = 0; c <= 86; c++) begin
            @(posedge clk); #1;
            case (c)
                0:  bus.game_state = 3'b001;
                13: bus.game_state = 3'b010;
                20: bus.game_state = 3'b001;
                26: begin d_cur = '{2, 0, 2}; clat_cur = 2; hit_cur = 1'b0; end
                46: begin d_cur = '{1, 1, 1}; clat_cur = 5; end
                52: bus.game_state = 3'b011;
                54: bus.game_state = 3'b001;
                56: begin d_cur = '{9, 1, 1}; clat_cur = 1; hit_cur = 1'b1; end
                default: ;
            endcase
            case (c)
                9:  check_val("nom_req_pre", 32'(bus.obj_req), 32'b000);
                10: begin
                    check_val("nom_req0", 32'(bus.obj_req), 32'b001);
                    check_val("nom_busy", 32'(bus.frame_busy), 32'd1);
                end
                12: check_val("nom_req1", 32'(bus.obj_req), 32'b010);
                15: check_val("pause_held", 32'(bus.obj_req), 32'b010);
                16: begin
                    check_val("pause_drop", 32'(bus.obj_req), 32'b000);
                    check_val("pause_busy", 32'(bus.frame_busy), 32'd1);
                end
                20: check_val("pause_hold", 32'(bus.obj_req), 32'b000);
                21: check_val("resume_req2", 32'(bus.obj_req), 32'b100);
                23: check_val("coll_start", 32'(bus.coll_start), 32'd1);
                24: check_val("coll_start_1cyc", 32'(bus.coll_start), 32'd0);
                25: begin
                    check_val("hit_dead", 32'(bus.dead), 32'd1);
                    check_val("hit_fcnt", 32'(bus.frame_cnt), 32'd1);
                end
                26: begin
                    check_val("dead_1cyc", 32'(bus.dead), 32'd0);
                    check_val("busy_low", 32'(bus.frame_busy), 32'd0);
                    check_val("frozen_no_tick", 32'(bus.obj_req), 32'b000);
                end
                27: begin
                    check_val("next_tick_req0", 32'(bus.obj_req), 32'b001);
                    check_val("no_ovr", 32'(bus.overrun), 32'd0);
                end
                36: begin
                    check_val("tmo_req1_held", 32'(bus.obj_req), 32'b010);
                    check_val("tmo_flag_pre", 32'(bus.timeout_err), 32'd0);
                    check_val("ovr_pre", 32'(bus.overrun), 32'd0);
                end
                37: begin
                    check_val("tmo_req2", 32'(bus.obj_req), 32'b100);
                    check_val("tmo_flag", 32'(bus.timeout_err), 32'd1);
                    check_val("ovr_set", 32'(bus.overrun), 32'd1);
                end
                39: check_val("tmo_coll_start", 32'(bus.coll_start), 32'd1);
                42: begin
                    check_val("tmo_dead", 32'(bus.dead), 32'd0);
                    check_val("tmo_fcnt", 32'(bus.frame_cnt), 32'd2);
                    check_val("tmo_busy", 32'(bus.frame_busy), 32'd1);
                end
                43: check_val("tmo_busy_low", 32'(bus.frame_busy), 32'd0);
                46: check_val("ovr_not_queued", 32'(bus.obj_req), 32'b000);
                47: check_val("f3_req0", 32'(bus.obj_req), 32'b001);
                50: check_val("f3_cs", 32'(bus.coll_start), 32'd1);
                53: check_all_zero("abort");
                56: begin
                    check_val("late_dead", 32'(bus.dead), 32'd0);
                    check_val("late_fcnt", 32'(bus.frame_cnt), 32'd0);
                    check_val("late_busy", 32'(bus.frame_busy), 32'd0);
                end
                63: check_val("f4_req_pre", 32'(bus.obj_req), 32'b000);
                64: check_val("f4_req0", 32'(bus.obj_req), 32'b001);
                71: begin
                    check_val("f4_req0_end", 32'(bus.obj_req), 32'b001);
                    check_val("f4_tmo_pre", 32'(bus.timeout_err), 32'd0);
                end
                72: begin
                    check_val("f4_req1", 32'(bus.obj_req), 32'b010);
                    check_val("f4_tmo", 32'(bus.timeout_err), 32'd1);
                end
                74: begin
                    check_val("f4_cs", 32'(bus.coll_start), 32'd1);
                    check_val("f4_ovr", 32'(bus.overrun), 32'd1);
                end
                76: begin
                    check_val("f4_dead", 32'(bus.dead), 32'd1);
                    check_val("f4_fcnt", 32'(bus.frame_cnt), 32'd1);
                end
                84: check_val("f5_req0", 32'(bus.obj_req), 32'b001);
                86: begin
                    check_val("pre_rst_fcnt", 32'(bus.frame_cnt), 32'd1);
                    check_val("pre_rst_busy", 32'(bus.frame_busy), 32'd1);
                end
                default: ;
            endcase
            respond();
        end

        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        @(posedge clk); #1;
        check_all_zero("rst_held");
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
